// File: rtl/pipectrl_n.sv
// rtl/pipectrl_n.sv - pipeline stall/flush/redirect controller for an NSTAGE-deep pipe
`timescale 1ns/1ps
module pipectrl_n #(
  parameter int                XLEN        = 32,
  parameter int                NSTAGE      = 6,
  parameter int                LU_STAGE    = 1,
  parameter int                LU_CYCLES   = 1,
  parameter int                REDIR_STAGE = 3,
  parameter int                TRAP_STAGE  = 4,
  parameter logic [NSTAGE-1:0] FREEZE_MASK = 6'b001000,
  parameter int                CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              loaduse_i,
  input  logic [NSTAGE-1:0] stall_req_i,
  input  logic              redir_i,
  input  logic [XLEN-1:0]   redir_addr_i,
  input  logic              trap_i,
  input  logic [XLEN-1:0]   trap_addr_i,
  output logic              je_o,
  output logic [XLEN-1:0]   jump_addr_o,
  output logic [NSTAGE-1:0] stall_o,
  output logic [NSTAGE-1:0] flush_o,
  output logic              pend_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [3:0]       LU_LOAD = 4'(LU_CYCLES - 1);

  logic [3:0]        lu_cnt_q, lu_cnt_d;
  logic              pend_q, pend_d;
  logic [XLEN-1:0]   pend_addr_q, pend_addr_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic              freeze;
  logic              use_trap, use_pend, use_redir, any_redir;
  logic              lu_act;
  logic [NSTAGE-1:0] req;
  logic [NSTAGE-1:0] stall_v, flush_v;
  logic [XLEN-1:0]   addr_v;
  logic              acc;

  // Redirect source selection and stall/flush vector composition
  always_comb begin
    freeze    = |(stall_req_i & FREEZE_MASK);
    use_trap  = !freeze && trap_i;
    use_pend  = !freeze && !trap_i && pend_q;
    use_redir = !freeze && !trap_i && !pend_q && redir_i;
    any_redir = use_trap || use_pend || use_redir;

    // A load-use pulse arriving with a redirect belongs to a squashed instruction
    lu_act = (loaduse_i && !any_redir) || (lu_cnt_q != 4'd0);

    req = stall_req_i;
    if (lu_act) req[LU_STAGE] = 1'b1;

    // Every stage at or below the highest requester holds; the next one gets a bubble
    acc     = 1'b0;
    stall_v = '0;
    flush_v = '0;
    for (int j = NSTAGE - 1; j >= 0; j--) begin
      acc        = acc | req[j];
      stall_v[j] = acc;
    end
    for (int j = 1; j < NSTAGE; j++) begin
      flush_v[j] = stall_v[j-1] && !stall_v[j];
    end

    addr_v = '0;
    if (use_trap) begin
      addr_v = trap_addr_i;
      for (int j = 0; j < NSTAGE; j++) begin
        if (j < TRAP_STAGE) begin
          stall_v[j] = 1'b0;
          if (j >= 1) flush_v[j] = 1'b1;
        end
      end
    end else if (use_pend || use_redir) begin
      addr_v = use_pend ? pend_addr_q : redir_addr_i;
      for (int j = 0; j < NSTAGE; j++) begin
        if (j < REDIR_STAGE) begin
          stall_v[j] = 1'b0;
          if (j >= 1) flush_v[j] = 1'b1;
        end
      end
    end

    if (freeze) begin
      stall_v = '1;
      flush_v = '0;
    end
  end

  // Next-state for load-use hold, pending redirect and stall counter
  always_comb begin
    lu_cnt_d    = lu_cnt_q;
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    stall_cnt_d = stall_cnt_q;

    if (freeze) begin
      if (trap_i) begin
        pend_d      = 1'b1;
        pend_addr_d = trap_addr_i;
      end else if (redir_i) begin
        pend_d      = 1'b1;
        pend_addr_d = redir_addr_i;
      end
    end else begin
      // Unfrozen: a held redirect is either issued now or superseded by a trap
      pend_d = 1'b0;
      if (any_redir)                lu_cnt_d = 4'd0;
      else if (loaduse_i)           lu_cnt_d = LU_LOAD;
      else if (lu_cnt_q != 4'd0)    lu_cnt_d = lu_cnt_q - 4'd1;
    end

    if (stall_v[0] && stall_cnt_q != CNT_MAX) stall_cnt_d = stall_cnt_q + 1'b1;
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lu_cnt_q    <= '0;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      lu_cnt_q    <= lu_cnt_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Outputs are forced quiet while reset is asserted
  always_comb begin
    je_o        = !rst && any_redir;
    jump_addr_o = rst ? '0 : addr_v;
    stall_o     = rst ? '0 : stall_v;
    flush_o     = rst ? '0 : flush_v;
    pend_o      = pend_q;
    stall_cnt_o = stall_cnt_q;
  end

endmodule

// File: tb/tb_pipectrl_n.sv
// tb/tb_pipectrl_n.sv - directed self-checking bench for pipectrl_n
`timescale 1ns/1ps
module tb_pipectrl_n;

  logic        clk = 1'b0;
  logic        rst;
  logic        loaduse_i;
  logic [5:0]  stall_req_i;
  logic        redir_i;
  logic [31:0] redir_addr_i;
  logic        trap_i;
  logic [31:0] trap_addr_i;
  logic        je_o;
  logic [31:0] jump_addr_o;
  logic [5:0]  stall_o;
  logic [5:0]  flush_o;
  logic        pend_o;
  logic [2:0]  stall_cnt_o;

  int passed = 0;
  int fails  = 0;
  int total  = 0;

  pipectrl_n #(.LU_CYCLES(2), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .loaduse_i(loaduse_i), .stall_req_i(stall_req_i),
    .redir_i(redir_i), .redir_addr_i(redir_addr_i), .trap_i(trap_i),
    .trap_addr_i(trap_addr_i), .je_o(je_o), .jump_addr_o(jump_addr_o),
    .stall_o(stall_o), .flush_o(flush_o), .pend_o(pend_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [5:0] st, input logic [5:0] fl,
                         input logic je, input logic [31:0] ja);
    chk({tag, ".stall"}, 32'(stall_o), 32'(st));
    chk({tag, ".flush"}, 32'(flush_o), 32'(fl));
    chk({tag, ".je"},    32'(je_o),    32'(je));
    chk({tag, ".addr"},  jump_addr_o,  ja);
  endtask

  // Advance to the next cycle, apply inputs, settle to mid-cycle for checking
  task automatic step(input logic lu, input logic [5:0] sreq, input logic rd,
                      input logic [31:0] ra, input logic tp, input logic [31:0] ta);
    @(posedge clk);
    #1;
    loaduse_i = lu; stall_req_i = sreq; redir_i = rd;
    redir_addr_i = ra; trap_i = tp; trap_addr_i = ta;
    #4;
  endtask

  task automatic idle();
    step(1'b0, 6'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    loaduse_i = 1'b0; stall_req_i = '0; redir_i = 1'b0;
    redir_addr_i = '0; trap_i = 1'b0; trap_addr_i = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Redirect issued from pend together with a fresh redir_i is illegal stimulus
  always @(negedge clk) begin
    if (!rst && pend_o && redir_i && !trap_i && !stall_req_i[3]) begin
      total++;
      fails++;
      $error("FAIL contract redir_with_pend got=1 exp=0");
    end
  end

  initial begin
    // Reset with busy inputs: every output must be quiet
    rst = 1'b1;
    loaduse_i = 1'b1; stall_req_i = 6'b111111; redir_i = 1'b1;
    redir_addr_i = 32'h1234; trap_i = 1'b1; trap_addr_i = 32'h5678;
    #4;
    chk_out("rst", 6'b0, 6'b0, 1'b0, 32'h0);
    chk("rst.pend", 32'(pend_o), 32'h0);
    chk("rst.cnt", 32'(stall_cnt_o), 32'h0);
    do_reset();

    // Two-cycle load-use hold
    idle();
    chk_out("idle", 6'b0, 6'b0, 1'b0, 32'h0);
    step(1'b1, 6'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk_out("lu0", 6'b000011, 6'b000100, 1'b0, 32'h0);
    idle();
    chk_out("lu1", 6'b000011, 6'b000100, 1'b0, 32'h0);
    idle();
    chk_out("lu2", 6'b0, 6'b0, 1'b0, 32'h0);
    chk("lu.cnt", 32'(stall_cnt_o), 32'd2);

    // Four-cycle freeze from stage 3
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 6'b001000, 1'b0, 32'h0, 1'b0, 32'h0);
      chk_out("frz", 6'b111111, 6'b0, 1'b0, 32'h0);
    end
    idle();
    chk_out("frz.end", 6'b0, 6'b0, 1'b0, 32'h0);
    chk("frz.cnt", 32'(stall_cnt_o), 32'd4);

    // Plain branch redirect
    step(1'b0, 6'b0, 1'b1, 32'h0000_1000, 1'b0, 32'h0);
    chk_out("br", 6'b0, 6'b000110, 1'b1, 32'h0000_1000);
    idle();
    chk_out("br.after", 6'b0, 6'b0, 1'b0, 32'h0);

    // Non-freezing stall requests, including the top stage
    step(1'b0, 6'b010000, 1'b0, 32'h0, 1'b0, 32'h0);
    chk_out("s4", 6'b011111, 6'b100000, 1'b0, 32'h0);
    step(1'b0, 6'b100000, 1'b0, 32'h0, 1'b0, 32'h0);
    chk_out("s5", 6'b111111, 6'b000000, 1'b0, 32'h0);

    // Branch together with a stall above the redirecting stage
    step(1'b0, 6'b010000, 1'b1, 32'h0000_1400, 1'b0, 32'h0);
    chk_out("br.s4", 6'b011000, 6'b100110, 1'b1, 32'h0000_1400);

    // Branch during a three-cycle freeze is held and issued afterwards
    step(1'b0, 6'b001000, 1'b1, 32'h0000_2000, 1'b0, 32'h0);
    chk_out("pf1", 6'b111111, 6'b0, 1'b0, 32'h0);
    chk("pf1.pend", 32'(pend_o), 32'h0);
    chk("pf1.cnt", 32'(stall_cnt_o), 32'd6);
    step(1'b0, 6'b001000, 1'b0, 32'h0, 1'b0, 32'h0);
    chk_out("pf2", 6'b111111, 6'b0, 1'b0, 32'h0);
    chk("pf2.pend", 32'(pend_o), 32'h1);
    step(1'b0, 6'b001000, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("pf3.je", 32'(je_o), 32'h0);
    chk("pf3.pend", 32'(pend_o), 32'h1);
    idle();
    chk_out("pf.issue", 6'b0, 6'b000110, 1'b1, 32'h0000_2000);
    idle();
    chk_out("pf.after", 6'b0, 6'b0, 1'b0, 32'h0);
    chk("pf.after.pend", 32'(pend_o), 32'h0);

    // Trap beats branch and load-use; the hold is cancelled
    step(1'b1, 6'b0, 1'b1, 32'h0000_3000, 1'b1, 32'h8000_0000);
    chk_out("trap", 6'b0, 6'b001110, 1'b1, 32'h8000_0000);
    idle();
    chk_out("trap.after", 6'b0, 6'b0, 1'b0, 32'h0);

    // Trap while a redirect is pending supersedes it
    step(1'b0, 6'b001000, 1'b1, 32'h0000_5000, 1'b0, 32'h0);
    step(1'b0, 6'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0100);
    chk_out("tp", 6'b0, 6'b001110, 1'b1, 32'h0000_0100);
    idle();
    chk("tp.pend", 32'(pend_o), 32'h0);
    chk("tp.je", 32'(je_o), 32'h0);

    // Long freeze saturates the 3-bit counter, then async reset mid-freeze
    do_reset();
    step(1'b0, 6'b001000, 1'b1, 32'h0000_4000, 1'b0, 32'h0);
    for (int k = 2; k <= 10; k++) begin
      step(1'b0, 6'b001000, 1'b0, 32'h0, 1'b0, 32'h0);
      if (k == 2) chk("sat.pend", 32'(pend_o), 32'h1);
    end
    chk("sat.cnt", 32'(stall_cnt_o), 32'd7);
    step(1'b0, 6'b001000, 1'b0, 32'h0, 1'b0, 32'h0);
    rst = 1'b1;
    #1;
    chk_out("arst", 6'b0, 6'b0, 1'b0, 32'h0);
    chk("arst.pend", 32'(pend_o), 32'h0);
    chk("arst.cnt", 32'(stall_cnt_o), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle();
    chk_out("arst.after", 6'b0, 6'b0, 1'b0, 32'h0);
    chk("arst.after.pend", 32'(pend_o), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pipectrl_n.md
Name: pipectrl_n

Overview:
- Parametrised pipeline controller for the RV32IM core, for an NSTAGE-deep pipeline.
- Stage indices: 0=PC, 1=IF, 2=ID, 3=EXE, 4=MEM, 5=WB at the default depth.
- Combines per-stage stall requests, a multi-cycle load-use hold, freeze requests (M-type), branch redirects and trap redirects into per-stage stall/flush vectors and the PC redirect.
- Adds a pending-redirect register so redirects raised during a freeze are not lost, plus a saturating stall-cycle counter.

Parameters:
XLEN, 32, address width
NSTAGE, 6, number of stages including PC (min 4)
LU_STAGE, 1, stage at which load-use stalls (stall 0..LU_STAGE, bubble at LU_STAGE+1)
LU_CYCLES, 1, cycles a load-use hold lasts (1..15)
REDIR_STAGE, 3, stage issuing branch/jump redirect
TRAP_STAGE, 4, stage issuing trap redirect (> REDIR_STAGE)
FREEZE_MASK, 6'b001000, stages whose stall_req freezes the whole pipe
CNT_W, 16, stall counter width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
loaduse_i  in  1  load-use hazard pulse from ID
stall_req_i  in  NSTAGE  per-stage stall request
redir_i  in  1  branch/jump taken, single-cycle pulse
redir_addr_i  in  XLEN  branch target
trap_i  in  1  trap, single-cycle pulse
trap_addr_i  in  XLEN  trap vector
je_o  out  1  PC redirect enable
jump_addr_o  out  XLEN  PC redirect target
stall_o  out  NSTAGE  per-stage hold
flush_o  out  NSTAGE  per-stage bubble insert
pend_o  out  1  pending redirect held
stall_cnt_o  out  CNT_W  saturating count of cycles with stall_o[0]=1

Behaviour:
- Reset (async): lu_cnt=0, pend=0, pend_addr=0, stall_cnt=0. All outputs are 0 while rst=1.
- freeze = |(stall_req_i & FREEZE_MASK).
- lu_act = loaduse_i | (lu_cnt!=0).
  - lu_cnt loads LU_CYCLES-1 on loaduse_i, else decrements to 0.
  - lu_act contributes a stall request at LU_STAGE.
- Freeze:
  - stall_o = all ones, flush_o = 0, je_o = 0.
  - Any redir_i/trap_i is latched into pend/pend_addr; trap wins if both.
  - lu_cnt holds its value.
- Non-freeze: h = highest index with an active stall request (including lu_act).
  - stall_o[j] = 1 for j ≤ h.
  - flush_o[h+1] = 1 if h+1 < NSTAGE.
  - No request: all 0.
- Redirect source priority, when not frozen: trap_i > pend > redir_i.
  - Selected source drives je_o=1 and jump_addr_o, combinationally in the same cycle.
  - Trap: flush_o[1..TRAP_STAGE-1]=1 and stall_o[0..TRAP_STAGE-1]=0.
  - Branch or pend: flush_o[1..REDIR_STAGE-1]=1 and stall_o[0..REDIR_STAGE-1]=0.
  - Stall/flush bits at or above the redirecting stage follow the non-freeze rule.
  - Any redirect clears lu_cnt; a loaduse_i in the same cycle is ignored.
  - Issuing pend clears it. trap_i while pend is set clears pend.
  - redir_i coinciding with pend issue is a contract violation (bench assertion).
- pend_o = pend register. jump_addr_o = 0 when je_o=0.
- stall_cnt increments when stall_o[0]=1 and saturates at 2^CNT_W-1.
- rst mid-freeze or mid-hold: pending redirect is discarded and the hold ends immediately.

Test Plan:
- LU_CYCLES=2, loaduse_i pulse at cycle 5 → stall_o=6'b000011 and flush_o=6'b000100 in cycles 5 and 6; all 0 in cycle 7; stall_cnt_o=2.
- stall_req_i[3]=1 for 4 cycles (freeze) → stall_o=6'b111111, flush_o=0 for 4 cycles; stall_cnt_o=4.
- redir_i with addr 0x0000_1000, no stall → same cycle je_o=1, jump_addr_o=0x1000, flush_o=6'b000110, stall_o=0.
- redir_i (0x2000) during a 3-cycle freeze → pend_o=1 from the next cycle; je_o=0 during freeze; first unfrozen cycle je_o=1, addr 0x2000, flush_o=6'b000110; pend_o=0 afterwards.
- trap_i (0x8000_0000) together with redir_i and loaduse_i → je_o=1, addr 0x8000_0000, flush_o=6'b001110, stall_o=0, lu_cnt=0.
- CNT_W=3 with a 10-cycle freeze → stall_cnt_o saturates at 7; assert rst mid-freeze with pend set → all outputs 0 asynchronously, pend_o=0 after release.
